// File: rtl/pwconv_mac_accum.sv
// Pointwise (1x1) convolution MAC stage: accumulates CIN activation*weight
// products per pixel into four biased 32-bit sums and issues them with the
// pixel's cnt/pos tags to the rescale/ReLU stage.
module pwconv_mac_accum #(
  parameter int CIN  = 16,
  parameter int CH_W = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               en,
  input  logic               clr,
  input  logic               in_valid,
  input  logic signed [7:0]  act,
  input  logic signed [7:0]  w0,
  input  logic signed [7:0]  w1,
  input  logic signed [7:0]  w2,
  input  logic signed [7:0]  w3,
  input  logic signed [31:0] bias0,
  input  logic signed [31:0] bias1,
  input  logic signed [31:0] bias2,
  input  logic signed [31:0] bias3,
  input  logic [4:0]         cnt_in,
  input  logic [3:0]         pos_in,
  output logic               out_valid,
  output logic [4:0]         cnt_out,
  output logic [3:0]         pos_out,
  output logic signed [31:0] data_out0,
  output logic signed [31:0] data_out1,
  output logic signed [31:0] data_out2,
  output logic signed [31:0] data_out3
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CIN - 1);

  logic signed [7:0]  w    [4];
  logic signed [31:0] bias [4];

  assign w[0] = w0;
  assign w[1] = w1;
  assign w[2] = w2;
  assign w[3] = w3;
  assign bias[0] = bias0;
  assign bias[1] = bias1;
  assign bias[2] = bias2;
  assign bias[3] = bias3;

  // Channel counter and stage-1 (product) registers
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               s1Valid_q, s1Valid_d;
  logic               s1First_q, s1First_d;
  logic               s1Last_q, s1Last_d;
  logic signed [15:0] prod_q [4];
  logic signed [15:0] prod_d [4];
  // Bias and tags travel with the channel-0 beat until the group finishes
  logic signed [31:0] bias_q [4];
  logic signed [31:0] bias_d [4];
  logic [4:0]         cntTag_q, cntTag_d;
  logic [3:0]         posTag_q, posTag_d;
  // Stage-2 accumulators and output registers
  logic signed [31:0] acc_q [4];
  logic signed [31:0] acc_d [4];
  logic signed [31:0] sum   [4];
  logic               outValid_q, outValid_d;
  logic [4:0]         cntOut_q, cntOut_d;
  logic [3:0]         posOut_q, posOut_d;
  logic signed [31:0] dataOut_q [4];
  logic signed [31:0] dataOut_d [4];

  // Next-state: clr aborts the group, otherwise advance both pipeline stages
  always_comb begin
    ch_d       = ch_q;
    s1Valid_d  = s1Valid_q;
    s1First_d  = s1First_q;
    s1Last_d   = s1Last_q;
    cntTag_d   = cntTag_q;
    posTag_d   = posTag_q;
    outValid_d = outValid_q;
    cntOut_d   = cntOut_q;
    posOut_d   = posOut_q;
    for (int k = 0; k < 4; k++) begin
      prod_d[k]    = prod_q[k];
      bias_d[k]    = bias_q[k];
      acc_d[k]     = acc_q[k];
      dataOut_d[k] = dataOut_q[k];
      sum[k]       = (s1First_q ? bias_q[k] : acc_q[k]) + 32'(prod_q[k]);
    end

    if (clr) begin
      ch_d       = '0;
      s1Valid_d  = 1'b0;
      outValid_d = 1'b0;
      for (int k = 0; k < 4; k++) acc_d[k] = '0;
    end else begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1First_d = (ch_q == '0);
        s1Last_d  = (ch_q == LAST_CH);
        ch_d      = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        for (int k = 0; k < 4; k++) prod_d[k] = 16'(act) * 16'(w[k]);
        if (ch_q == '0) begin
          cntTag_d = cnt_in;
          posTag_d = pos_in;
          for (int k = 0; k < 4; k++) bias_d[k] = bias[k];
        end
      end

      outValid_d = 1'b0;
      if (s1Valid_q) begin
        for (int k = 0; k < 4; k++) acc_d[k] = sum[k];
        if (s1Last_q) begin
          outValid_d = 1'b1;
          cntOut_d   = cntTag_q;
          posOut_d   = posTag_q;
          for (int k = 0; k < 4; k++) dataOut_d[k] = sum[k];
        end
      end
    end
  end

  // State registers: async clear, frozen whenever en is low
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ch_q       <= '0;
      s1Valid_q  <= 1'b0;
      s1First_q  <= 1'b0;
      s1Last_q   <= 1'b0;
      cntTag_q   <= '0;
      posTag_q   <= '0;
      outValid_q <= 1'b0;
      cntOut_q   <= '0;
      posOut_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        prod_q[k]    <= '0;
        bias_q[k]    <= '0;
        acc_q[k]     <= '0;
        dataOut_q[k] <= '0;
      end
    end else if (en) begin
      ch_q       <= ch_d;
      s1Valid_q  <= s1Valid_d;
      s1First_q  <= s1First_d;
      s1Last_q   <= s1Last_d;
      cntTag_q   <= cntTag_d;
      posTag_q   <= posTag_d;
      outValid_q <= outValid_d;
      cntOut_q   <= cntOut_d;
      posOut_q   <= posOut_d;
      for (int k = 0; k < 4; k++) begin
        prod_q[k]    <= prod_d[k];
        bias_q[k]    <= bias_d[k];
        acc_q[k]     <= acc_d[k];
        dataOut_q[k] <= dataOut_d[k];
      end
    end
  end

  assign out_valid = outValid_q;
  assign cnt_out   = cntOut_q;
  assign pos_out   = posOut_q;
  assign data_out0 = dataOut_q[0];
  assign data_out1 = dataOut_q[1];
  assign data_out2 = dataOut_q[2];
  assign data_out3 = dataOut_q[3];

endmodule

// File: tb/tb_pwconv_mac_accum.sv
// Directed bench for pwconv_mac_accum: full groups, back-to-back groups,
// enable freeze, clr abort and mid-group async reset, with hand-computed sums.
module tb_pwconv_mac_accum;

  logic               clk;
  logic               rst_b;
  logic               en;
  logic               clr;
  logic               in_valid;
  logic signed [7:0]  act, w0, w1, w2, w3;
  logic signed [31:0] bias0, bias1, bias2, bias3;
  logic [4:0]         cnt_in;
  logic [3:0]         pos_in;
  logic               out_valid;
  logic [4:0]         cnt_out;
  logic [3:0]         pos_out;
  logic signed [31:0] data_out0, data_out1, data_out2, data_out3;

  int errors = 0;
  int checks = 0;

  pwconv_mac_accum #(.CIN(16), .CH_W(4)) dut (
    .clk(clk), .rst_b(rst_b), .en(en), .clr(clr), .in_valid(in_valid),
    .act(act), .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .bias0(bias0), .bias1(bias1), .bias2(bias2), .bias3(bias3),
    .cnt_in(cnt_in), .pos_in(pos_in),
    .out_valid(out_valid), .cnt_out(cnt_out), .pos_out(pos_out),
    .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, settle 1 unit after it
  task automatic applyStimulus(input logic v, input logic c,
                               input logic signed [7:0] a, input logic signed [7:0] k0,
                               input logic signed [7:0] k1, input logic signed [7:0] k2,
                               input logic signed [7:0] k3,
                               input logic signed [31:0] b0, input logic signed [31:0] b1,
                               input logic signed [31:0] b2, input logic signed [31:0] b3,
                               input logic [4:0] cn, input logic [3:0] ps);
    in_valid = v; clr = c; act = a;
    w0 = k0; w1 = k1; w2 = k2; w3 = k3;
    bias0 = b0; bias1 = b1; bias2 = b2; bias3 = b3;
    cnt_in = cn; pos_in = ps;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 0, 0, 0, 0, 5'd0, 4'd0);
  endtask

  // n consecutive valid beats carrying identical act/weights/bias/tags
  task automatic applyBeats(input int n, input logic signed [7:0] a,
                            input logic signed [7:0] k0, input logic signed [7:0] k1,
                            input logic signed [7:0] k2, input logic signed [7:0] k3,
                            input logic signed [31:0] b0, input logic signed [31:0] b1,
                            input logic signed [31:0] b2, input logic signed [31:0] b3,
                            input logic [4:0] cn, input logic [3:0] ps);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, a, k0, k1, k2, k3, b0, b1, b2, b3, cn, ps);
  endtask

  // Directed sequence of scenarios
  initial begin
    rst_b = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0;
    act = 0; w0 = 0; w1 = 0; w2 = 0; w3 = 0;
    bias0 = 0; bias1 = 0; bias2 = 0; bias3 = 0; cnt_in = 0; pos_in = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_data0", data_out0, 0);
    checkOutput("rst_cnt", 32'(cnt_out), 0);
    rst_b = 1'b1;
    idleCycle();

    // Basic group: act=1, w=1,2,-1,0
    applyBeats(16, 8'sd1, 8'sd1, 8'sd2, -8'sd1, 8'sd0, 0, 0, 0, 0, 5'd5, 4'd3);
    checkOutput("t1_not_yet", 32'(out_valid), 0);
    idleCycle();
    checkOutput("t1_valid", 32'(out_valid), 1);
    checkOutput("t1_data0", data_out0, 16);
    checkOutput("t1_data1", data_out1, 32);
    checkOutput("t1_data2", data_out2, -16);
    checkOutput("t1_data3", data_out3, 0);
    checkOutput("t1_cnt", 32'(cnt_out), 5);
    checkOutput("t1_pos", 32'(pos_out), 3);
    idleCycle();
    checkOutput("t1_drop", 32'(out_valid), 0);
    checkOutput("t1_hold0", data_out0, 16);

    // Extreme operands with bias
    applyBeats(16, 8'sd127, -8'sd128, 8'sd1, 8'sd0, -8'sd1, 1000, 5, 0, 0, 5'd7, 4'd9);
    idleCycle();
    checkOutput("t2_valid", 32'(out_valid), 1);
    checkOutput("t2_data0", data_out0, -259096);
    checkOutput("t2_data1", data_out1, 2037);
    checkOutput("t2_data2", data_out2, 0);
    checkOutput("t2_data3", data_out3, -2032);

    // Back-to-back groups, no bubble
    applyBeats(16, 8'sd2, 8'sd3, 8'sd0, 8'sd0, 8'sd0, 10, 0, 0, 0, 5'd1, 4'd1);
    applyBeats(1, -8'sd1, 8'sd5, 8'sd0, 8'sd0, 8'sd0, 0, 0, 0, 0, 5'd2, 4'd2);
    checkOutput("t3_a_valid", 32'(out_valid), 1);
    checkOutput("t3_a_data0", data_out0, 106);
    checkOutput("t3_a_cnt", 32'(cnt_out), 1);
    checkOutput("t3_a_pos", 32'(pos_out), 1);
    applyBeats(15, -8'sd1, 8'sd5, 8'sd0, 8'sd0, 8'sd0, 0, 0, 0, 0, 5'd2, 4'd2);
    checkOutput("t3_gap_valid", 32'(out_valid), 0);
    idleCycle();
    checkOutput("t3_b_valid", 32'(out_valid), 1);
    checkOutput("t3_b_data0", data_out0, -80);
    checkOutput("t3_b_cnt", 32'(cnt_out), 2);
    checkOutput("t3_b_pos", 32'(pos_out), 2);

    // Freeze on the valid cycle; beats offered while frozen must be ignored
    applyBeats(16, 8'sd1, 8'sd4, 8'sd0, 8'sd0, 8'sd0, -5, 0, 0, 0, 5'd3, 4'd7);
    idleCycle();
    checkOutput("t4_valid", 32'(out_valid), 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'sd100, 8'sd100, 8'sd0, 8'sd0, 8'sd0, 0, 0, 0, 0, 5'd9, 4'd9);
      checkOutput("t4_hold_valid", 32'(out_valid), 1);
      checkOutput("t4_hold_data0", data_out0, 59);
    end
    en = 1'b1;
    idleCycle();
    checkOutput("t4_drop", 32'(out_valid), 0);
    checkOutput("t4_keep_data0", data_out0, 59);
    checkOutput("t4_keep_cnt", 32'(cnt_out), 3);

    // Abort after 7 beats; the beat offered with clr is dropped
    applyBeats(7, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 50, 50, 50, 50, 5'd8, 4'd8);
    applyStimulus(1'b1, 1'b1, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 50, 50, 50, 50, 5'd8, 4'd8);
    checkOutput("t5_clr_valid", 32'(out_valid), 0);
    checkOutput("t5_clr_keep0", data_out0, 59);
    applyBeats(16, 8'sd1, 8'sd1, -8'sd2, 8'sd0, 8'sd0, 100, 0, 0, 0, 5'd4, 4'd5);
    checkOutput("t5_no_pulse", 32'(out_valid), 0);
    idleCycle();
    checkOutput("t5_valid", 32'(out_valid), 1);
    checkOutput("t5_data0", data_out0, 116);
    checkOutput("t5_data1", data_out1, -32);
    checkOutput("t5_cnt", 32'(cnt_out), 4);

    // Async reset in the middle of a group
    applyBeats(5, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 7, 7, 7, 7, 5'd6, 4'd6);
    rst_b = 1'b0;
    #2;
    checkOutput("t6_rst_valid", 32'(out_valid), 0);
    checkOutput("t6_rst_data0", data_out0, 0);
    checkOutput("t6_rst_cnt", 32'(cnt_out), 0);
    @(negedge clk);
    rst_b = 1'b1;
    applyBeats(16, -8'sd2, 8'sd7, 8'sd0, 8'sd1, 8'sd0, 0, 0, -1, 0, 5'd9, 4'd2);
    idleCycle();
    checkOutput("t6_valid", 32'(out_valid), 1);
    checkOutput("t6_data0", data_out0, -224);
    checkOutput("t6_data2", data_out2, -33);
    checkOutput("t6_cnt", 32'(cnt_out), 9);
    checkOutput("t6_pos", 32'(pos_out), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
